// File: rtl/rr_arb_mux.sv
// N_CH:1 round-robin arbitrating mux with valid/ready on every port and one registered output stage.
// Define RR_ARB_MUX_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N_CH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(N_CH)-1:0] out_sel,
    input  logic                    out_ready
);

    localparam int SEL_W = $clog2(N_CH);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   base;
    logic [SEL_W-1:0]   grant;
    logic [SEL_W-1:0]   idx;
    logic [SEL_W:0]     sum;
    logic               any_valid;
    logic               load;
    logic               take;
    logic               drain;
    logic [WIDTH-1:0]   ch_data [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_split
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [SEL_W-1:0] rr_ptr;
    assign base = rr_ptr;
`endif

    // Scan from base upward with wrap; the first valid channel found wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            sum = {1'b0, base} + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(N_CH)) begin
                sum = sum - (SEL_W+1)'(N_CH);
            end
            idx = sum[SEL_W-1:0];
            if (!any_valid && in_valid[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

    assign out_valid = (state == FULL);
    assign load      = ~out_valid | out_ready;
    assign take      = load & any_valid & ~rst;
    assign drain     = out_valid & out_ready;
    assign in_ready  = take ? (N_CH'(1) << grant) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (take) state_nxt = FULL;
            FULL:    if (drain && !take) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= '0;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (take) begin
                out_data <= ch_data[grant];
                out_sel  <= grant;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
                rr_ptr   <= (grant == SEL_W'(N_CH-1)) ? '0 : grant + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux (WIDTH=32, N_CH=4): stimulus pushes expected beats, a monitor pops them.
module tb_rr_arb_mux;

    localparam int WIDTH = 32;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_ready;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [WIDTH-1:0]       chan_val [N_CH];
    logic [SEL_W+WIDTH-1:0] sb_q [$];

    rr_arb_mux #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_chan(input int ch, input logic [WIDTH-1:0] v);
        chan_val[ch] = v;
        in_data[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic push(input int ch);
        sb_q.push_back({SEL_W'(ch), chan_val[ch]});
    endtask

    task automatic after_pos();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest expected beat.
    initial begin
        logic [SEL_W+WIDTH-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", {out_sel, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp = sb_q.pop_front();
                    check("beat_sel", out_sel, exp[SEL_W+WIDTH-1:WIDTH]);
                    check("beat_data", out_data, exp[WIDTH-1:0]);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N_CH; i++) set_chan(i, 32'hA000_0000 + WIDTH'(i));
        after_pos();

        // Reset state, idle.
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t1_out_valid", out_valid, 0);
            check("t1_out_data", out_data, 0);
            check("t1_out_sel", out_sel, 0);
            check("t1_in_ready", in_ready, 0);
            after_pos();
        end

        // All channels valid: grants rotate 0..3 twice.
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("t2_in_ready", in_ready, 4'b0001 << (c % 4));
            push(c % 4);
            after_pos();
        end
        in_valid = '0;
        after_pos();
        after_pos();

        // Single channel with stall, then drain plus same-cycle refill.
        set_chan(2, 32'hDEAD_BEEF);
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        @(negedge clk);
        check("t3_first_ready", in_ready, 4'b0100);
        push(2);
        after_pos();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t3_stall_valid", out_valid, 1);
            check("t3_stall_data", out_data, 32'hDEAD_BEEF);
            check("t3_stall_sel", out_sel, 2);
            check("t3_stall_ready", in_ready, 0);
            after_pos();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_refill_ready", in_ready, 4'b0100);
        push(2);
        after_pos();
        in_valid = '0;
        after_pos();
        after_pos();

        // Pointer at 3: grant ch3, wrap, then alternate between ch0 and ch3.
        in_valid = 4'b1000;
        @(negedge clk);
        check("t4_ch3_ready", in_ready, 4'b1000);
        push(3);
        after_pos();
        in_valid = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t4_alt_ready", in_ready, (c % 2 == 0) ? 4'b0001 : 4'b1000);
            push((c % 2 == 0) ? 0 : 3);
            after_pos();
        end
        in_valid = '0;
        after_pos();
        after_pos();

        // Held ch1 beat discarded by reset; pointer back to 0.
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        @(negedge clk);
        check("t5_load_ready", in_ready, 4'b0010);
        after_pos();
        rst      = 1'b1;
        in_valid = 4'b0110;
        @(negedge clk);
        check("t5_rst_ready", in_ready, 0);
        check("t5_held_valid", out_valid, 1);
        after_pos();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_post_valid", out_valid, 0);
        check("t5_post_data", out_data, 0);
        check("t5_post_sel", out_sel, 0);
        check("t5_first_grant", in_ready, 4'b0010);
        push(1);
        after_pos();
        @(negedge clk);
        check("t5_second_grant", in_ready, 4'b0100);
        push(2);
        after_pos();
        in_valid = '0;
        after_pos();
        after_pos();

        // ch1 and ch3 continuously valid, pointer at 3.
        in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            int g;
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
            g = 1;
`else
            g = (c % 2 == 0) ? 3 : 1;
`endif
            @(negedge clk);
            check("t6_grant", in_ready, 4'b0001 << g);
            push(g);
            after_pos();
        end
        in_valid = '0;
        after_pos();
        after_pos();

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
